// File: rtl/sc_ball_shifter_pkg.sv
// Shared encodings for the ball shifter: FSM states, server identity, serve positions.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sc_ball_shifter_pkg;

  // Default width of the LED position bus.
  localparam int BALL_WIDTH = 8;

  // Serve positions for the default bus width: player 1 owns the MSB, player 2 the LSB.
  localparam logic [BALL_WIDTH-1:0] SERVE_POS_JUG1 = 8'b1000_0000;
  localparam logic [BALL_WIDTH-1:0] SERVE_POS_JUG2 = 8'b0000_0001;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MOVE_R = 2'b01,
    MOVE_L = 2'b10,
    POINT  = 2'b11
  } ballState_t;

  typedef enum logic {
    JUG1 = 1'b0,
    JUG2 = 1'b1
  } server_t;

endpackage

// File: rtl/sc_ball_hitlatch.sv
// Remembers a paddle press made while the ball sits at that player's end, until the next tick.
// Latency: set/clear registered one cycle after the qualifying input; the tick clear has priority.
// Backpressure: none; free-running.
module sc_ball_hitlatch (
  input  logic clk,
  input  logic resetInLow,
  input  logic enable,
  input  logic button_InLow,
  input  logic tick,
  output logic latched
);

  // Clear on every movement tick, otherwise set on a press inside the hit window.
  always_ff @(posedge clk or negedge resetInLow) begin
    if (!resetInLow) begin
      latched <= 1'b0;
    end else if (tick) begin
      latched <= 1'b0;
    end else if (enable && !button_InLow) begin
      latched <= 1'b1;
    end
  end

endmodule

// File: rtl/sc_ball_shifter.sv
// Moves a one-hot ball across the LED bus, bounces it on in-time hits and scores misses.
// Latency: bus, direction and point pulses update on the clock edge that samples the tick.
// Backpressure: none; ticks are consumed unconditionally, start only matters in IDLE.
module sc_ball_shifter
  import sc_ball_shifter_pkg::*;
#(
  parameter int SC_BALLSHIFTER_DATAWIDTH = BALL_WIDTH,
  parameter int SC_BALLSHIFTER_HOLDTICKS = 4
) (
  input  logic                                SC_BALLSHIFTER_CLOCK_50,
  input  logic                                SC_BALLSHIFTER_RESET_InLow,
  input  logic                                SC_BALLSHIFTER_tick_InHigh,
  input  logic                                SC_BALLSHIFTER_start_InLow,
  input  logic                                SC_BALLSHIFTER_hitJUG1_InLow,
  input  logic                                SC_BALLSHIFTER_hitJUG2_InLow,
  input  logic                                SC_BALLSHIFTER_endJUG1_InLow,
  input  logic                                SC_BALLSHIFTER_endJUG2_InLow,
  output logic [SC_BALLSHIFTER_DATAWIDTH-1:0] SC_BALLSHIFTER_data_OutBUS,
  output logic                                SC_BALLSHIFTER_pointJUG1_OutHigh,
  output logic                                SC_BALLSHIFTER_pointJUG2_OutHigh,
  output logic                                SC_BALLSHIFTER_dirRight_OutHigh
);

  localparam int W  = SC_BALLSHIFTER_DATAWIDTH;
  localparam int CW = $clog2(SC_BALLSHIFTER_HOLDTICKS + 1);
  localparam logic [W-1:0]  POS_JUG1  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  POS_JUG2  = W'(1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SC_BALLSHIFTER_HOLDTICKS - 1);

  ballState_t    state;
  server_t       server;
  logic [W-1:0]  ballBus;
  logic [CW-1:0] holdCnt;
  logic          pointJug1;
  logic          pointJug2;
  logic          dirRight;

  logic tick;
  logic enableJug1;
  logic enableJug2;
  logic latchedJug1;
  logic latchedJug2;
  logic hitJug1;
  logic hitJug2;

  assign tick = SC_BALLSHIFTER_tick_InHigh;

  // Hit window: ball sits at the player's end and is travelling toward them.
  assign enableJug1 = (state == MOVE_L) && !SC_BALLSHIFTER_endJUG1_InLow;
  assign enableJug2 = (state == MOVE_R) && !SC_BALLSHIFTER_endJUG2_InLow;

  // A press landing in the same cycle as the deciding tick still counts.
  assign hitJug1 = latchedJug1 || (enableJug1 && !SC_BALLSHIFTER_hitJUG1_InLow);
  assign hitJug2 = latchedJug2 || (enableJug2 && !SC_BALLSHIFTER_hitJUG2_InLow);

  sc_ball_hitlatch uHitJug1 (
    .clk          (SC_BALLSHIFTER_CLOCK_50),
    .resetInLow   (SC_BALLSHIFTER_RESET_InLow),
    .enable       (enableJug1),
    .button_InLow (SC_BALLSHIFTER_hitJUG1_InLow),
    .tick         (tick),
    .latched      (latchedJug1)
  );

  sc_ball_hitlatch uHitJug2 (
    .clk          (SC_BALLSHIFTER_CLOCK_50),
    .resetInLow   (SC_BALLSHIFTER_RESET_InLow),
    .enable       (enableJug2),
    .button_InLow (SC_BALLSHIFTER_hitJUG2_InLow),
    .tick         (tick),
    .latched      (latchedJug2)
  );

  // Rally FSM: every output is a register, so the comparators never see a combinational path.
  always_ff @(posedge SC_BALLSHIFTER_CLOCK_50 or negedge SC_BALLSHIFTER_RESET_InLow) begin
    if (!SC_BALLSHIFTER_RESET_InLow) begin
      state     <= IDLE;
      server    <= JUG1;
      ballBus   <= POS_JUG1;
      holdCnt   <= '0;
      pointJug1 <= 1'b0;
      pointJug2 <= 1'b0;
      dirRight  <= 1'b1;
    end else begin
      pointJug1 <= 1'b0;
      pointJug2 <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!SC_BALLSHIFTER_start_InLow) begin
              state    <= (server == JUG1) ? MOVE_R : MOVE_L;
              dirRight <= (server == JUG1);
            end
          end
          MOVE_R: begin
            if (SC_BALLSHIFTER_endJUG2_InLow) begin
              ballBus <= ballBus >> 1;
            end else if (hitJug2) begin
              state    <= MOVE_L;
              ballBus  <= ballBus << 1;
              dirRight <= 1'b0;
            end else begin
              state     <= POINT;
              ballBus   <= '0;
              pointJug1 <= 1'b1;
              server    <= JUG2;
              holdCnt   <= '0;
            end
          end
          MOVE_L: begin
            if (SC_BALLSHIFTER_endJUG1_InLow) begin
              ballBus <= ballBus << 1;
            end else if (hitJug1) begin
              state    <= MOVE_R;
              ballBus  <= ballBus >> 1;
              dirRight <= 1'b1;
            end else begin
              state     <= POINT;
              ballBus   <= '0;
              pointJug2 <= 1'b1;
              server    <= JUG1;
              holdCnt   <= '0;
            end
          end
          POINT: begin
            if (holdCnt == HOLD_LAST) begin
              state    <= IDLE;
              holdCnt  <= '0;
              ballBus  <= (server == JUG1) ? POS_JUG1 : POS_JUG2;
              dirRight <= (server == JUG1);
            end else begin
              holdCnt <= holdCnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign SC_BALLSHIFTER_data_OutBUS       = ballBus;
  assign SC_BALLSHIFTER_pointJUG1_OutHigh = pointJug1;
  assign SC_BALLSHIFTER_pointJUG2_OutHigh = pointJug2;
  assign SC_BALLSHIFTER_dirRight_OutHigh  = dirRight;

endmodule

// File: tb/tb_sc_ball_shifter.sv
// Directed rally bench with a queue of expected output snapshots and immediate-assertion checks.
// Latency: each expectation is compared 1 time unit after the clock edge that consumes the step.
// Backpressure: none; the bench drives ticks and buttons directly.
module tb_sc_ball_shifter;

  typedef struct packed {
    logic [7:0] bus;
    logic       p1;
    logic       p2;
    logic       dir;
  } snap_t;

  logic       clk;
  logic       rstN;
  logic       tick;
  logic       startN;
  logic       hit1N;
  logic       hit2N;
  logic       end1N;
  logic       end2N;
  logic [7:0] busOut;
  logic       point1;
  logic       point2;
  logic       dirRight;

  int    total = 0;
  int    bad   = 0;
  snap_t expQ[$];

  sc_ball_shifter #(
    .SC_BALLSHIFTER_DATAWIDTH (8),
    .SC_BALLSHIFTER_HOLDTICKS (4)
  ) dut (
    .SC_BALLSHIFTER_CLOCK_50          (clk),
    .SC_BALLSHIFTER_RESET_InLow       (rstN),
    .SC_BALLSHIFTER_tick_InHigh       (tick),
    .SC_BALLSHIFTER_start_InLow       (startN),
    .SC_BALLSHIFTER_hitJUG1_InLow     (hit1N),
    .SC_BALLSHIFTER_hitJUG2_InLow     (hit2N),
    .SC_BALLSHIFTER_endJUG1_InLow     (end1N),
    .SC_BALLSHIFTER_endJUG2_InLow     (end2N),
    .SC_BALLSHIFTER_data_OutBUS       (busOut),
    .SC_BALLSHIFTER_pointJUG1_OutHigh (point1),
    .SC_BALLSHIFTER_pointJUG2_OutHigh (point2),
    .SC_BALLSHIFTER_dirRight_OutHigh  (dirRight)
  );

  // Side comparators: each end flag goes low while the ball sits on that end LED.
  assign end1N = ~busOut[7];
  assign end2N = ~busOut[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic checkOut(input string tag);
    snap_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = expQ.pop_front();
      chk({tag, ".bus"}, busOut, e.bus);
      chk({tag, ".p1"}, {7'd0, point1}, {7'd0, e.p1});
      chk({tag, ".p2"}, {7'd0, point2}, {7'd0, e.p2});
      chk({tag, ".dir"}, {7'd0, dirRight}, {7'd0, e.dir});
    end
  endtask

  // One clock cycle with a tick strobe, then compare.
  task automatic tickStep(input logic [7:0] eb, input logic ep1, input logic ep2,
                          input logic edir, input string tag);
    expQ.push_back('{bus: eb, p1: ep1, p2: ep2, dir: edir});
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    checkOut(tag);
  endtask

  // One clock cycle without a tick: the outputs must hold (pulses drop).
  task automatic idleStep(input logic [7:0] eb, input logic edir, input string tag);
    expQ.push_back('{bus: eb, p1: 1'b0, p2: 1'b0, dir: edir});
    @(posedge clk);
    #1;
    checkOut(tag);
  endtask

  initial begin
    tick   = 1'b0;
    startN = 1'b1;
    hit1N  = 1'b1;
    hit2N  = 1'b1;
    rstN   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    idleStep(8'h80, 1'b1, "reset");

    // Serve by player 1: the serve tick does not move the ball.
    startN = 1'b0;
    tickStep(8'h80, 1'b0, 1'b0, 1'b1, "serve1");
    startN = 1'b1;
    idleStep(8'h80, 1'b1, "serve1_hold");

    // Walk to the player-2 end, one LED per tick, stable between ticks.
    for (int i = 1; i < 8; i++) begin
      tickStep(8'h80 >> i, 1'b0, 1'b0, 1'b1, "walkR");
      if (i == 3) idleStep(8'h80 >> i, 1'b1, "walkR_stable");
    end

    // Short press inside the window is latched, next tick reverses.
    hit2N = 1'b0;
    @(posedge clk);
    #1;
    hit2N = 1'b1;
    idleStep(8'h01, 1'b1, "latch_wait");
    tickStep(8'h02, 1'b0, 1'b0, 1'b0, "hit2_latched");

    for (int i = 2; i < 8; i++) tickStep(8'h01 << i, 1'b0, 1'b0, 1'b0, "walkL");

    // Player 1 presses in the very cycle of the deciding tick.
    hit1N = 1'b0;
    tickStep(8'h40, 1'b0, 1'b0, 1'b1, "hit1_same_cycle");
    hit1N = 1'b1;

    for (int i = 2; i < 6; i++) tickStep(8'h80 >> i, 1'b0, 1'b0, 1'b1, "walkR2");

    // Early press held from 00000100 and released before the decision is a miss.
    hit2N = 1'b0;
    tickStep(8'h02, 1'b0, 1'b0, 1'b1, "early_hold_a");
    tickStep(8'h01, 1'b0, 1'b0, 1'b1, "early_hold_b");
    hit2N = 1'b1;
    idleStep(8'h01, 1'b1, "early_release");
    tickStep(8'h00, 1'b1, 1'b0, 1'b1, "miss2_point1");
    idleStep(8'h00, 1'b1, "point1_one_cycle");

    // Blanking hold, then player 2 serves from the LSB.
    for (int i = 0; i < 3; i++) tickStep(8'h00, 1'b0, 1'b0, 1'b1, "hold1");
    tickStep(8'h01, 1'b0, 1'b0, 1'b0, "hold1_exit");
    startN = 1'b0;
    tickStep(8'h01, 1'b0, 1'b0, 1'b0, "serve2");
    startN = 1'b1;
    tickStep(8'h02, 1'b0, 1'b0, 1'b0, "serve2_move");

    // Player 1 misses: player 2 scores, serve returns to player 1.
    for (int i = 2; i < 8; i++) tickStep(8'h01 << i, 1'b0, 1'b0, 1'b0, "walkL2");
    tickStep(8'h00, 1'b0, 1'b1, 1'b0, "miss1_point2");
    idleStep(8'h00, 1'b0, "point2_one_cycle");
    for (int i = 0; i < 3; i++) tickStep(8'h00, 1'b0, 1'b0, 1'b0, "hold2");
    tickStep(8'h80, 1'b0, 1'b0, 1'b1, "hold2_exit");

    // Start is ignored outside IDLE; player 2 hits in the cycle of the tick.
    startN = 1'b0;
    tickStep(8'h80, 1'b0, 1'b0, 1'b1, "serve3");
    for (int i = 1; i < 8; i++) tickStep(8'h80 >> i, 1'b0, 1'b0, 1'b1, "walkR3");
    startN = 1'b1;
    hit2N = 1'b0;
    tickStep(8'h02, 1'b0, 1'b0, 1'b0, "hit2_same_cycle");
    hit2N = 1'b1;
    for (int i = 2; i < 8; i++) tickStep(8'h01 << i, 1'b0, 1'b0, 1'b0, "walkL3");
    hit1N = 1'b0;
    tickStep(8'h40, 1'b0, 1'b0, 1'b1, "hit1_again");
    hit1N = 1'b1;
    tickStep(8'h20, 1'b0, 1'b0, 1'b1, "walkR4a");
    tickStep(8'h10, 1'b0, 1'b0, 1'b1, "walkR4b");

    // Mid-rally reset takes effect before the next clock edge.
    #2;
    rstN = 1'b0;
    #1;
    expQ.push_back('{bus: 8'h80, p1: 1'b0, p2: 1'b0, dir: 1'b1});
    checkOut("async_reset");
    @(negedge clk);
    rstN = 1'b1;
    idleStep(8'h80, 1'b1, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_ball_shifter.md
Name: sc_ball_shifter

Overview:
- Drives the ball-position bus that the per-player side comparators read.
- Holds a one-hot ball position, shifts it one LED per movement tick, and reverses direction when the player at the active end hits in time.
- Scores a point for the opponent on a miss.
- Sits between the game prescaler (tick source), the player buttons and the side comparators; the comparators' active-low end flags come back in as inputs.

Parameters:
- SC_BALLSHIFTER_DATAWIDTH, 8, width of the position bus; the ball is one-hot, MSB = player-1 end, LSB = player-2 end.
- SC_BALLSHIFTER_HOLDTICKS, 4, number of ticks the bus is blanked after a point.

Ports:
- SC_BALLSHIFTER_CLOCK_50  in  1  system clock, all state on rising edge.
- SC_BALLSHIFTER_RESET_InLow  in  1  asynchronous active-low reset.
- SC_BALLSHIFTER_tick_InHigh  in  1  one-cycle movement strobe from the prescaler.
- SC_BALLSHIFTER_start_InLow  in  1  serve request, level.
- SC_BALLSHIFTER_hitJUG1_InLow  in  1  player-1 paddle button.
- SC_BALLSHIFTER_hitJUG2_InLow  in  1  player-2 paddle button.
- SC_BALLSHIFTER_endJUG1_InLow  in  1  comparator flag, ball at MSB.
- SC_BALLSHIFTER_endJUG2_InLow  in  1  comparator flag, ball at LSB.
- SC_BALLSHIFTER_data_OutBUS  out  DATAWIDTH  ball position, one-hot or all-zero.
- SC_BALLSHIFTER_pointJUG1_OutHigh  out  1  one-cycle pulse, player 1 scores.
- SC_BALLSHIFTER_pointJUG2_OutHigh  out  1  one-cycle pulse, player 2 scores.
- SC_BALLSHIFTER_dirRight_OutHigh  out  1  1 = ball moving toward the LSB.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, server JUG1, bus = MSB only (8'b10000000), point pulses 0, dirRight 1, hit latches 0, hold counter 0. Reset mid-rally aborts immediately, with no point.
- States: IDLE, MOVE_R, MOVE_L, POINT.
- IDLE:
  - Bus shows the server's position: MSB for JUG1, LSB for JUG2.
  - When start is low on a tick, go to MOVE_R if the server is JUG1, else MOVE_L.
  - The bus does not move on that tick.
  - start is ignored in all other states.
- MOVE_R, on tick:
  - If endJUG2 is high: bus shifts right by 1.
  - If endJUG2 is low and hitJUG2 is latched: go to MOVE_L, bus shifts left by 1, dirRight goes to 0.
  - If endJUG2 is low and no hit is latched: go to POINT, bus goes to 0, pointJUG1 pulses on the cycle of entry, server becomes JUG2.
- MOVE_L: mirror of MOVE_R, using endJUG1, hitJUG1 and pointJUG2; on a miss the server becomes JUG1.
- Hit latch, one per player:
  - Sets while that player's end flag is low, the ball travels toward that player, and their button is low.
  - Clears on every tick.
  - A button press in the same cycle as the deciding tick counts as a hit.
  - Presses while the ball is elsewhere are ignored, so early pressing gives no advantage.
  - Both buttons pressed together: only the player at the active end matters.
- POINT:
  - Bus is 0; the hold counter increments on each tick.
  - After HOLDTICKS ticks, go to IDLE and load the new server's serve position.
- Latency: the bus changes on the clock edge following the tick cycle, i.e. registered one cycle after the tick.
- The bus is always registered and never combinationally derived from inputs, so there is no loop through the comparators.
- Ticks are ignored while the tick is low; the bus is stable between ticks.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE = 2'b00, MOVE_R = 2'b01, MOVE_L = 2'b10, POINT = 2'b11);
  - serve positions (MSB-one-hot, LSB-one-hot);
  - the server encoding (JUG1 = 0, JUG2 = 1).
- Natural sub-module: sc_ball_hitlatch, instantiated twice. It is a set/clear flop with inputs enable, button_InLow and tick, and output latched.

Test Plan:
- Reset, then release: bus = 8'b10000000, dirRight = 1, no pulses. Assert reset while the bus = 8'b00010000 in MOVE_R: the bus returns to 8'b10000000 asynchronously, before the next clock edge.
- start low plus 1 tick, then 7 more ticks: the bus walks 10000000 → 01000000 → … → 00000001, one step per tick, with no movement between ticks.
- Ball at 00000001 with endJUG2 = 0; hitJUG2 pulsed low for 1 cycle mid-window, then a tick: state MOVE_L, bus = 00000010, dirRight = 0.
- Ball at 00000001 with no hit, then a tick: bus = 0 and pointJUG1 high for exactly 1 cycle. After 4 more ticks: IDLE with bus = 00000001 (JUG2 serves). A following serve moves the bus to 00000010.
- hitJUG2 held low from bus = 00000100 but released before the ball reaches LSB, then a tick at LSB: counts as a miss, pointJUG1 pulses.
- hitJUG2 goes low in the same cycle as the tick at LSB: counts as a hit, and the ball reverses.
